// File: rtl/oled_pkg.sv
// Shared definitions for the OLED SPI streamer: register map, status bits,
// shift-engine states and the tagged byte carried through the FIFO.
package oled_pkg;

  localparam int unsigned IDX_WIDTH = 3;

  localparam logic [IDX_WIDTH-1:0] REG_CTRL   = 3'd0;
  localparam logic [IDX_WIDTH-1:0] REG_STATUS = 3'd1;
  localparam logic [IDX_WIDTH-1:0] REG_CMD    = 3'd2;
  localparam logic [IDX_WIDTH-1:0] REG_DATA   = 3'd3;
  localparam logic [IDX_WIDTH-1:0] REG_FILL   = 3'd4;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_DIV_LSB = 8;

  localparam int unsigned ST_BUSY      = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_EMPTY     = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_FERR      = 4;
  localparam int unsigned ST_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    LOW  = 2'd2,
    HIGH = 2'd3
  } shift_state_t;

  typedef struct packed {
    logic       dnc;
    logic [7:0] data;
  } oled_byte_t;

endpackage

// File: rtl/oled_byte_fifo.sv
// Synchronous FIFO of tagged OLED bytes; pushes while full are dropped,
// head_c is the combinational view of the oldest entry.
module oled_byte_fifo
  import oled_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  oled_byte_t                    push_data,
  input  logic                          pop,
  output oled_byte_t                    head_c,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  oled_byte_t        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_d;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    level_d = level;
    if (do_push && !do_pop) begin
      level_d = level + LW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level - LW'(1);
    end
  end

  // Flags are registered from the next level so they line up with level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_d;
      full  <= (level_d == LW'(FIFO_DEPTH));
      empty <= (level_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/oled_spi_streamer.sv
// AHB-Lite slave that queues command/data bytes and streams them to a 4-wire
// SPI OLED. Define OLED_FILL_EN to add the hardware solid-colour fill engine.
module oled_spi_streamer
  import oled_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DIV_WIDTH  = 8,
  parameter int unsigned RESET_DIV  = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        nCS,
  output logic        DnC,
  output logic        SDIN,
  output logic        SCLK
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                 ph_wr;
  logic                 ph_rd;
  logic [IDX_WIDTH-1:0] ph_idx;
  logic                 wr_ctrl;
  logic                 wr_status;
  logic                 push_req;

  logic                 en;
  logic [DIV_WIDTH-1:0] div;
  logic                 ovf;
  logic                 ferr;
  logic                 fill_active;
  logic                 busy;

  oled_byte_t           push_byte;
  oled_byte_t           fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_level;
  logic                 fifo_pop;

  oled_byte_t           src_byte;
  logic                 src_avail;
  logic                 src_pop;

  shift_state_t         state;
  shift_state_t         state_d;
  logic [DIV_WIDTH-1:0] cur_div;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [2:0]           bit_cnt;
  logic [7:0]           shreg;

  logic                 unused_ok;

  assign HREADYOUT = 1'b1;
  assign unused_ok = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

  // AHB address phase capture; the write itself happens in the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ph_wr  <= 1'b0;
      ph_rd  <= 1'b0;
      ph_idx <= '0;
    end else begin
      ph_wr  <= HSEL & HREADY & HTRANS[1] & HWRITE;
      ph_rd  <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
      ph_idx <= HADDR[4:2];
    end
  end

  assign wr_ctrl   = ph_wr & (ph_idx == REG_CTRL);
  assign wr_status = ph_wr & (ph_idx == REG_STATUS);
  assign push_req  = ph_wr & ((ph_idx == REG_CMD) | (ph_idx == REG_DATA));

  always_comb begin
    push_byte      = '0;
    push_byte.dnc  = (ph_idx == REG_DATA);
    push_byte.data = HWDATA[7:0];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en  <= 1'b0;
      div <= DIV_WIDTH'(RESET_DIV);
      ovf <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en  <= HWDATA[CTRL_EN];
        div <= HWDATA[CTRL_DIV_LSB +: DIV_WIDTH];
      end
      if (push_req && fifo_full) begin
        ovf <= 1'b1;
      end else if (wr_status && HWDATA[ST_OVF]) begin
        ovf <= 1'b0;
      end
    end
  end

  oled_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst       (HRESET),
    .push      (push_req),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .head_c    (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign src_pop = (state == LOAD);

`ifdef OLED_FILL_EN
  logic        wr_fill;
  logic        fill_hi;
  logic [15:0] fill_colour;
  logic [15:0] fill_cnt;

  assign wr_fill = ph_wr & (ph_idx == REG_FILL);

  // Fill engine: stands in for the FIFO as byte source, high colour byte first.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      fill_active <= 1'b0;
      fill_hi     <= 1'b0;
      fill_colour <= '0;
      fill_cnt    <= '0;
      ferr        <= 1'b0;
    end else begin
      if (wr_fill) begin
        if (fifo_empty && !fill_active) begin
          if (HWDATA[31:16] != '0) begin
            fill_active <= 1'b1;
            fill_hi     <= 1'b1;
            fill_colour <= HWDATA[15:0];
            fill_cnt    <= HWDATA[31:16];
          end
        end else begin
          ferr <= 1'b1;
        end
      end else if (wr_status && HWDATA[ST_FERR]) begin
        ferr <= 1'b0;
      end
      if (src_pop && fill_active) begin
        fill_hi <= ~fill_hi;
        if (!fill_hi) begin
          fill_cnt <= fill_cnt - 16'd1;
          if (fill_cnt == 16'd1) fill_active <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    src_byte = fifo_head;
    if (fill_active) begin
      src_byte.dnc  = 1'b1;
      src_byte.data = fill_hi ? fill_colour[15:8] : fill_colour[7:0];
    end
  end

  assign src_avail = fill_active | ~fifo_empty;
  assign fifo_pop  = src_pop & ~fill_active;
`else
  assign fill_active = 1'b0;
  assign ferr        = 1'b0;
  assign src_byte    = fifo_head;
  assign src_avail   = ~fifo_empty;
  assign fifo_pop    = src_pop;
`endif

  assign busy = (state != IDLE) | fill_active;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (en && src_avail) state_d = LOAD;
      LOAD: state_d = LOW;
      LOW:  if (div_cnt == '0) state_d = HIGH;
      HIGH: begin
        if (div_cnt == '0) begin
          if (bit_cnt == 3'd7) state_d = (en && src_avail) ? LOAD : IDLE;
          else                 state_d = LOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift datapath; nCS/SCLK are registered decodes of the next state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cur_div <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      nCS     <= 1'b1;
      SCLK    <= 1'b0;
      SDIN    <= 1'b0;
      DnC     <= 1'b0;
    end else begin
      nCS  <= (state_d == IDLE);
      SCLK <= (state_d == HIGH);
      case (state)
        LOAD: begin
          cur_div <= div;
          div_cnt <= div;
          bit_cnt <= '0;
          shreg   <= src_byte.data;
          SDIN    <= src_byte.data[7];
          DnC     <= src_byte.dnc;
        end
        LOW: begin
          div_cnt <= (div_cnt == '0) ? cur_div : div_cnt - DIV_WIDTH'(1);
        end
        HIGH: begin
          if (div_cnt == '0) begin
            div_cnt <= cur_div;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7) begin
              shreg <= {shreg[6:0], 1'b0};
              SDIN  <= shreg[6];
            end
          end else begin
            div_cnt <= div_cnt - DIV_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    if (ph_rd) begin
      case (ph_idx)
        REG_CTRL: begin
          HRDATA[CTRL_EN]                   = en;
          HRDATA[CTRL_DIV_LSB +: DIV_WIDTH] = div;
        end
        REG_STATUS: begin
          HRDATA[ST_BUSY]              = busy;
          HRDATA[ST_FULL]              = fifo_full;
          HRDATA[ST_EMPTY]             = fifo_empty;
          HRDATA[ST_OVF]               = ovf;
          HRDATA[ST_FERR]              = ferr;
          HRDATA[ST_LEVEL_LSB +: 8]    = 8'(fifo_level);
        end
        default: HRDATA = '0;
      endcase
    end
  end

endmodule
